// File: rtl/fabric_irq_ctrl.sv
// Fabric IRQ controller: synchronises fabric IRQ lines, latches edge/level pending bits and
// arbitrates one masked request with an ack handshake. Optional: IRQ_ROUND_ROBIN_EN.
module fabric_irq_ctrl #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               UserCLK,
  input  logic               reset,
  input  logic               CONFIGURED,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_edge_mode,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] irq_pending
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e               state_q;
  logic                 irq_req_q;
  logic [ID_W-1:0]      irq_id_q;

  logic [NUM_IRQ-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0]   sync_val;
  logic [NUM_IRQ-1:0]   prev_q;
  logic [NUM_IRQ-1:0]   sticky_q, sticky_d;
  logic [NUM_IRQ-1:0]   edge_set;
  logic [NUM_IRQ-1:0]   ack_clr;
  logic [NUM_IRQ-1:0]   level_pend;
  logic [NUM_IRQ-1:0]   eligible;
  logic                 ack_fire;
  logic                 found;
  logic [ID_W-1:0]      winner;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

  // prev tracks even while unconfigured so a line already high at configure is not an edge.
  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending bits
  // ---------------------------------------------------------------------------
  assign ack_fire = (state_q == StReq) && irq_ack;
  assign edge_set = irq_edge_mode & sync_val & ~prev_q & {NUM_IRQ{CONFIGURED}};
  assign ack_clr  = ack_fire ? (NUM_IRQ'(1) << irq_id_q) : '0;

  always_comb begin
    sticky_d = '0;
    if (CONFIGURED) begin
      // Set wins over clear so an edge landing on the ack cycle is kept.
      sticky_d = (sticky_q & ~ack_clr) | edge_set;
    end
  end

  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign level_pend  = ~irq_edge_mode & sync_val;
  assign irq_pending = ((irq_edge_mode & sticky_q) | level_pend) & {NUM_IRQ{CONFIGURED}};
  assign eligible    = irq_pending & irq_mask;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W:0]      rr_base;
  logic [ID_W:0]      rr_sum;
  logic [NUM_IRQ-1:0] rr_rot;

  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      last_grant_q <= '0;
    end else if (CONFIGURED && ack_fire) begin
      last_grant_q <= irq_id_q;
    end
  end

  // Rotate so bit 0 is the line after the last grant, then pick the lowest set bit.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    rr_sum  = '0;
    rr_base = {1'b0, last_grant_q} + 1'b1;
    if (rr_base >= (ID_W+1)'(NUM_IRQ)) begin
      rr_base = '0;
    end
    rr_rot = NUM_IRQ'({eligible, eligible} >> rr_base);
    for (int j = 0; j < int'(NUM_IRQ); j++) begin
      if (!found && rr_rot[j]) begin
        found  = 1'b1;
        rr_sum = rr_base + (ID_W+1)'(j);
      end
    end
    if (rr_sum >= (ID_W+1)'(NUM_IRQ)) begin
      rr_sum = rr_sum - (ID_W+1)'(NUM_IRQ);
    end
    winner = rr_sum[ID_W-1:0];
  end
`else
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (!found && eligible[i]) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Request / ack FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
    end else if (!CONFIGURED) begin
      state_q   <= StIdle;
      irq_req_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            irq_id_q  <= winner;
            irq_req_q <= 1'b1;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (irq_ack) begin
            irq_req_q <= 1'b0;
            state_q   <= StHold;
          end
        end
        StHold: begin
          state_q <= StIdle;
        end
        default: begin
          irq_req_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_fabric_irq_ctrl.sv
// Directed bench for fabric_irq_ctrl: level-mode vector table plus hand sequences for
// latency, arbitration, ack/edge races, masking and asynchronous reset.
module tb_fabric_irq_ctrl;

  localparam int unsigned NUM_IRQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned SYNC    = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               CONFIGURED;
  logic [NUM_IRQ-1:0] irq_in;
  logic [NUM_IRQ-1:0] irq_edge_mode;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               irq_ack;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_IRQ-1:0] irq_pending;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] in_v;
    logic [3:0] mask;
    logic [3:0] exp_pend;
    logic       exp_req;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[7];

  fabric_irq_ctrl #(
    .NUM_IRQ    (NUM_IRQ),
    .ID_W       (ID_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .UserCLK      (clk),
    .reset        (reset),
    .CONFIGURED   (CONFIGURED),
    .irq_in       (irq_in),
    .irq_edge_mode(irq_edge_mode),
    .irq_mask     (irq_mask),
    .irq_ack      (irq_ack),
    .irq_req      (irq_req),
    .irq_id       (irq_id),
    .irq_pending  (irq_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!irq_req && n < 20) begin
      tick();
      n++;
    end
    check({name, " req timeout"}, irq_req, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{in_v: 4'b0001, mask: 4'b1111, exp_pend: 4'b0001, exp_req: 1'b1, exp_id: 2'd0};
    vecs[1] = '{in_v: 4'b1010, mask: 4'b1111, exp_pend: 4'b1010, exp_req: 1'b1, exp_id: 2'd1};
    vecs[2] = '{in_v: 4'b1010, mask: 4'b1101, exp_pend: 4'b1010, exp_req: 1'b1, exp_id: 2'd3};
    vecs[3] = '{in_v: 4'b0110, mask: 4'b1001, exp_pend: 4'b0110, exp_req: 1'b0, exp_id: 2'd0};
    vecs[4] = '{in_v: 4'b1111, mask: 4'b1000, exp_pend: 4'b1111, exp_req: 1'b1, exp_id: 2'd3};
    vecs[5] = '{in_v: 4'b1100, mask: 4'b1111, exp_pend: 4'b1100, exp_req: 1'b1, exp_id: 2'd2};
    vecs[6] = '{in_v: 4'b0000, mask: 4'b1111, exp_pend: 4'b0000, exp_req: 1'b0, exp_id: 2'd0};

    reset         = 1'b1;
    CONFIGURED    = 1'b0;
    irq_in        = '0;
    irq_edge_mode = 4'hF;
    irq_mask      = 4'hF;
    irq_ack       = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset req", irq_req, 0);
    check("reset id", irq_id, 0);
    check("reset pending", irq_pending, 0);

    // Unconfigured: line 1 high is ignored, and configuring with it high is not an edge.
    irq_in = 4'b0010;
    repeat (6) tick();
    check("unconf pending", irq_pending, 0);
    check("unconf req", irq_req, 0);
    CONFIGURED = 1'b1;
    repeat (6) tick();
    check("conf-high req", irq_req, 0);
    check("conf-high pending", irq_pending, 0);
    irq_in = '0;
    repeat (4) tick();

    // Level-mode vector table
    irq_edge_mode = 4'h0;
    for (int i = 0; i < 7; i++) begin
      irq_in   = vecs[i].in_v;
      irq_mask = vecs[i].mask;
      repeat (SYNC + 3) tick();
      check($sformatf("vec%0d pending", i), irq_pending, vecs[i].exp_pend);
      check($sformatf("vec%0d req", i), irq_req, vecs[i].exp_req);
      if (vecs[i].exp_req) check($sformatf("vec%0d id", i), irq_id, vecs[i].exp_id);
      irq_in = '0;
      repeat (SYNC + 2) tick();
      if (irq_req) do_ack();
      repeat (3) tick();
      check($sformatf("vec%0d idle", i), irq_req, 0);
    end
    irq_edge_mode = 4'hF;
    irq_mask      = 4'hF;

    // Latency: single-cycle pulse on line 2
    irq_in = 4'b0100;
    tick();
    irq_in = '0;
    repeat (SYNC - 1) tick();
    check("lat pending early", irq_pending, 0);
    tick();
    check("lat pending set", irq_pending, 4'b0100);
    check("lat req early", irq_req, 0);
    tick();
    check("lat req", irq_req, 1);
    check("lat id", irq_id, 2);
    repeat (3) tick();
    check("lat req held", irq_req, 1);
    do_ack();
    check("lat ack req", irq_req, 0);
    check("lat ack pending", irq_pending, 0);
    tick();
    check("lat idle", irq_req, 0);

    // Lines 0 and 3 together
    irq_in = 4'b1001;
    tick();
    irq_in = '0;
    repeat (SYNC + 1) tick();
    check("pair req", irq_req, 1);
    check("pair pending", irq_pending, 4'b1001);
`ifdef IRQ_ROUND_ROBIN_EN
    check("pair id first", irq_id, 3);
`else
    check("pair id first", irq_id, 0);
`endif
    do_ack();
    check("pair hold", irq_req, 0);
    tick();
    check("pair idle", irq_req, 0);
    tick();
    check("pair req2", irq_req, 1);
`ifdef IRQ_ROUND_ROBIN_EN
    check("pair id second", irq_id, 0);
`else
    check("pair id second", irq_id, 3);
`endif
    do_ack();
    repeat (2) tick();
    check("pair done req", irq_req, 0);
    check("pair done pending", irq_pending, 0);

    // Level line 1 held high: re-request after HOLD
    irq_edge_mode = 4'b1101;
    irq_in        = 4'b0010;
    wait_req("lvl");
    check("lvl id", irq_id, 1);
    do_ack();
    check("lvl hold", irq_req, 0);
    tick();
    check("lvl idle", irq_req, 0);
    tick();
    check("lvl rereq", irq_req, 1);
    check("lvl rereq id", irq_id, 1);
    irq_in = '0;
    repeat (SYNC + 2) tick();
    check("lvl drop req held", irq_req, 1);
    check("lvl drop pending", irq_pending, 0);
    do_ack();
    repeat (5) tick();
    check("lvl no rereq", irq_req, 0);
    irq_edge_mode = 4'hF;

    // New edge on line 2 lands on the ack cycle that clears line 2
    irq_in = 4'b0100;
    tick();
    irq_in = '0;
    wait_req("race");
    check("race id", irq_id, 2);
    irq_in = 4'b0100;
    tick();
    irq_in = '0;
    repeat (SYNC - 1) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("race hold req", irq_req, 0);
    check("race pending kept", irq_pending, 4'b0100);
    tick();
    tick();
    check("race rereq", irq_req, 1);
    check("race rereq id", irq_id, 2);
    irq_mask = 4'b1011;
    repeat (3) tick();
    check("mask req held", irq_req, 1);
    check("mask id held", irq_id, 2);
    do_ack();
    check("mask ack req", irq_req, 0);
    check("mask ack pending", irq_pending, 0);
    irq_mask = 4'hF;
    repeat (3) tick();
    check("mask idle", irq_req, 0);

    // Asynchronous reset during a request
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    wait_req("rst");
    reset = 1'b1;
    #1;
    check("rst async req", irq_req, 0);
    check("rst async pending", irq_pending, 0);
    check("rst async id", irq_id, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
    check("rst no replay req", irq_req, 0);
    check("rst no replay pending", irq_pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
